// File: rtl/act_arbiter_if.sv
// Request/response and act_mem bus bundle for act_arbiter.
// slave is the arbiter's view; master is the requesters plus act_mem.
interface act_arbiter_if #(
    parameter int BLOCK_COUNT_BITS = 6,
    parameter int ENTRY_W          = 8
);
    logic                        m_req_valid;
    logic                        m_req_ready;
    logic                        m_req_we;
    logic [BLOCK_COUNT_BITS-1:0] m_req_addr;
    logic [ENTRY_W-1:0]          m_req_wdata;
    logic                        m_resp_valid;
    logic [ENTRY_W-1:0]          m_resp_rdata;

    logic                        d_req_valid;
    logic                        d_req_ready;
    logic                        d_req_we;
    logic [BLOCK_COUNT_BITS-1:0] d_req_addr;
    logic [ENTRY_W-1:0]          d_req_wdata;
    logic                        d_resp_valid;
    logic [ENTRY_W-1:0]          d_resp_rdata;

    logic                        act_cs;
    logic                        act_sel;
    logic                        act_m_we;
    logic [BLOCK_COUNT_BITS-1:0] act_m_addr;
    logic [ENTRY_W-1:0]          act_m_wdata;
    logic                        act_d_we;
    logic [BLOCK_COUNT_BITS-1:0] act_d_addr;
    logic [ENTRY_W-1:0]          act_d_wdata;
    logic [ENTRY_W-1:0]          act_m_rdata;
    logic [ENTRY_W-1:0]          act_d_rdata;
    logic                        act_bsy;

    modport master (
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata,
        input  m_req_ready, m_resp_valid, m_resp_rdata,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_rdata,
        input  act_cs, act_sel,
        input  act_m_we, act_m_addr, act_m_wdata,
        input  act_d_we, act_d_addr, act_d_wdata,
        output act_m_rdata, act_d_rdata, act_bsy
    );

    modport slave (
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata,
        output m_req_ready, m_resp_valid, m_resp_rdata,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_rdata,
        output act_cs, act_sel,
        output act_m_we, act_m_addr, act_m_wdata,
        output act_d_we, act_d_addr, act_d_wdata,
        input  act_m_rdata, act_d_rdata, act_bsy
    );
endinterface

// File: rtl/act_arbiter.sv
// Round-robin arbiter sharing act_mem between the malloc and dealloc engines.
// Optional statistics counters are enabled with `define ACT_ARB_STATS_EN.
module act_arbiter #(
    parameter int GUARD_CYCLES     = 1,
    parameter int BLOCK_COUNT_BITS = 6,
    parameter int ENTRY_W          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    act_arbiter_if.slave  bus,
    output logic          arb_busy
`ifdef ACT_ARB_STATS_EN
    ,
    output logic [15:0]   m_grant_cnt,
    output logic [15:0]   d_grant_cnt,
    output logic [15:0]   conflict_cnt,
    output logic [7:0]    drop_cnt
`endif
);

    localparam int GUARD_LOAD = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
    localparam int GUARD_W    = (GUARD_LOAD < 2) ? 1 : $clog2(GUARD_LOAD + 1);

    typedef enum logic [2:0] {
        INIT,
        GUARD,
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [GUARD_W-1:0]          guard_cnt;
    logic [GUARD_W-1:0]          guard_next;
    logic                        rr_last;
    logic                        op_we;
    logic                        op_sel;
    logic [BLOCK_COUNT_BITS-1:0] op_addr;
    logic [ENTRY_W-1:0]          op_wdata;
    logic [ENTRY_W-1:0]          m_rdata_q;
    logic [ENTRY_W-1:0]          d_rdata_q;

    logic grant_m;
    logic grant_d;
    logic can_accept;
    logic m_accept;
    logic d_accept;
    logic accept;
    logic issue_live;
    logic m_done;
    logic d_done;

    // rr_last=1 means dealloc was served last, so malloc wins the next tie.
    assign grant_m    = bus.m_req_valid && (!bus.d_req_valid || rr_last);
    assign grant_d    = bus.d_req_valid && (!bus.m_req_valid || !rr_last);
    assign can_accept = (state == IDLE) && !bus.act_bsy;
    assign m_accept   = can_accept && grant_m;
    assign d_accept   = can_accept && grant_d;
    assign accept     = m_accept || d_accept;

    assign bus.m_req_ready = m_accept;
    assign bus.d_req_ready = d_accept;

    // A busy act_mem in the issue cycle kills the chip select outright.
    assign issue_live  = (state == ISSUE) && !bus.act_bsy;
    assign bus.act_cs  = issue_live;
    assign bus.act_sel = issue_live && op_sel;

    assign bus.act_m_we    = issue_live && !op_sel && op_we;
    assign bus.act_m_addr  = (issue_live && !op_sel) ? op_addr  : '0;
    assign bus.act_m_wdata = (issue_live && !op_sel) ? op_wdata : '0;
    assign bus.act_d_we    = issue_live && op_sel && op_we;
    assign bus.act_d_addr  = (issue_live && op_sel) ? op_addr  : '0;
    assign bus.act_d_wdata = (issue_live && op_sel) ? op_wdata : '0;

    // act_mem registers its read data, so it is valid during WAIT; writes keep the last read value.
    assign m_done            = (state == WAIT) && !op_sel;
    assign d_done            = (state == WAIT) && op_sel;
    assign bus.m_resp_valid  = m_done;
    assign bus.d_resp_valid  = d_done;
    assign bus.m_resp_rdata  = (m_done && !op_we) ? bus.act_m_rdata : m_rdata_q;
    assign bus.d_resp_rdata  = (d_done && !op_we) ? bus.act_d_rdata : d_rdata_q;

    assign arb_busy = (state != IDLE);

    // Next-state logic; a rising act_bsy outside INIT restarts the reset sweep wait.
    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        case (state)
            INIT: begin
                if (!bus.act_bsy) begin
                    state_next = GUARD;
                    guard_next = GUARD_W'(GUARD_LOAD);
                end
            end
            GUARD: begin
                if (bus.act_bsy) begin
                    state_next = INIT;
                end else begin
                    guard_next = guard_cnt - 1'b1;
                    if (guard_cnt <= 1) begin
                        state_next = IDLE;
                    end
                end
            end
            IDLE: begin
                if (bus.act_bsy) begin
                    state_next = INIT;
                end else if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = bus.act_bsy ? INIT : WAIT;
            WAIT:    state_next = bus.act_bsy ? INIT : IDLE;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            guard_cnt <= '0;
            rr_last   <= 1'b1;
            op_we     <= 1'b0;
            op_sel    <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            m_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_next;
            if (accept) begin
                op_sel   <= d_accept;
                rr_last  <= d_accept;
                op_we    <= d_accept ? bus.d_req_we    : bus.m_req_we;
                op_addr  <= d_accept ? bus.d_req_addr  : bus.m_req_addr;
                op_wdata <= d_accept ? bus.d_req_wdata : bus.m_req_wdata;
            end
            if (m_done && !op_we) begin
                m_rdata_q <= bus.act_m_rdata;
            end
            if (d_done && !op_we) begin
                d_rdata_q <= bus.act_d_rdata;
            end
        end
    end

`ifdef ACT_ARB_STATS_EN
    // Saturating counters: grants per side, contended idle cycles, ops killed by act_bsy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (m_accept && (m_grant_cnt != '1)) begin
                m_grant_cnt <= m_grant_cnt + 1'b1;
            end
            if (d_accept && (d_grant_cnt != '1)) begin
                d_grant_cnt <= d_grant_cnt + 1'b1;
            end
            if ((state == IDLE) && bus.m_req_valid && bus.d_req_valid && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            if ((state == ISSUE) && bus.act_bsy && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_act_arbiter.sv
// Directed bench for act_arbiter: reset sweep hold-off, single ops, round-robin,
// act_bsy abort and asynchronous reset, against a small registered act_mem model.
module tb_act_arbiter;

    localparam int ABITS = 6;
    localparam int EW    = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic arb_busy;

    int checks = 0;
    int errors = 0;

`ifdef ACT_ARB_STATS_EN
    logic [15:0] m_grant_cnt;
    logic [15:0] d_grant_cnt;
    logic [15:0] conflict_cnt;
    logic [7:0]  drop_cnt;
`endif

    act_arbiter_if #(.BLOCK_COUNT_BITS(ABITS), .ENTRY_W(EW)) bus ();

    act_arbiter #(
        .GUARD_CYCLES(1),
        .BLOCK_COUNT_BITS(ABITS),
        .ENTRY_W(EW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .arb_busy(arb_busy)
`ifdef ACT_ARB_STATS_EN
        ,
        .m_grant_cnt(m_grant_cnt),
        .d_grant_cnt(d_grant_cnt),
        .conflict_cnt(conflict_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // act_mem stand-in: entry i starts as i, one shared array, read data registered.
    logic [EW-1:0] mem [1<<ABITS];
    bit            mem_ready;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << ABITS); i++) mem[i] <= EW'(i);
            bus.act_m_rdata <= '0;
            bus.act_d_rdata <= '0;
            mem_ready       <= 1'b1;
        end else if (bus.act_cs) begin
            if (!bus.act_sel) begin
                if (bus.act_m_we) mem[bus.act_m_addr] <= bus.act_m_wdata;
                else              bus.act_m_rdata     <= mem[bus.act_m_addr];
            end else begin
                if (bus.act_d_we) mem[bus.act_d_addr] <= bus.act_d_wdata;
                else              bus.act_d_rdata     <= mem[bus.act_d_addr];
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int mg, dg, mr, dr, last_cyc;
        logic exp_d;

        rst_n           = 1'b0;
        bus.act_bsy     = 1'b1;
        bus.m_req_valid = 1'b1;
        bus.m_req_we    = 1'b1;
        bus.m_req_addr  = 6'd5;
        bus.m_req_wdata = 8'h82;
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = '0;
        bus.d_req_wdata = '0;
        #1;
        check_output("rst_arb_busy", arb_busy, 1);
        check_output("rst_m_ready", bus.m_req_ready, 0);
        check_output("rst_act_cs", bus.act_cs, 0);
        check_output("rst_m_resp_valid", bus.m_resp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset sweep in progress: nothing may reach act_mem.
        bad = 0;
        for (int i = 0; i < 65; i++) begin
            tick();
            if (bus.act_cs || bus.m_req_ready) bad++;
        end
        check_output("sweep_quiet", bad, 0);
        bus.act_bsy = 1'b0;
        #1;
        check_output("bsy_fall_ready", bus.m_req_ready, 0);
        tick();
        #1;
        check_output("guard_ready", bus.m_req_ready, 0);
        check_output("guard_cs", bus.act_cs, 0);
        tick();
        #1;
        check_output("idle_ready", bus.m_req_ready, 1);
        check_output("idle_arb_busy", arb_busy, 0);

        // Malloc write of entry 5.
        tick();
        bus.m_req_valid = 1'b0;
        #1;
        check_output("mw_cs", bus.act_cs, 1);
        check_output("mw_sel", bus.act_sel, 0);
        check_output("mw_we", bus.act_m_we, 1);
        check_output("mw_addr", bus.act_m_addr, 5);
        check_output("mw_wdata", bus.act_m_wdata, 8'h82);
        check_output("mw_d_we", bus.act_d_we, 0);
        check_output("mw_ready_low", bus.m_req_ready, 0);
        tick();
        #1;
        check_output("mw_resp", bus.m_resp_valid, 1);
        check_output("mw_cs_once", bus.act_cs, 0);
        check_output("mw_no_d_resp", bus.d_resp_valid, 0);
        tick();

        // Malloc read of entry 5.
        bus.m_req_valid = 1'b1;
        bus.m_req_we    = 1'b0;
        #1;
        check_output("mr_ready", bus.m_req_ready, 1);
        tick();
        bus.m_req_valid = 1'b0;
        #1;
        check_output("mr_cs", bus.act_cs, 1);
        check_output("mr_we", bus.act_m_we, 0);
        tick();
        #1;
        check_output("mr_resp", bus.m_resp_valid, 1);
        check_output("mr_rdata", bus.m_resp_rdata, 8'h82);
        tick();
        #1;
        check_output("mr_resp_end", bus.m_resp_valid, 0);
        check_output("mr_rdata_hold", bus.m_resp_rdata, 8'h82);

        // Dealloc write of the last entry.
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b1;
        bus.d_req_addr  = 6'd63;
        bus.d_req_wdata = 8'h83;
        #1;
        check_output("dw_ready", bus.d_req_ready, 1);
        check_output("dw_m_ready", bus.m_req_ready, 0);
        tick();
        bus.d_req_valid = 1'b0;
        #1;
        check_output("dw_cs", bus.act_cs, 1);
        check_output("dw_sel", bus.act_sel, 1);
        check_output("dw_d_we", bus.act_d_we, 1);
        check_output("dw_m_we", bus.act_m_we, 0);
        check_output("dw_addr", bus.act_d_addr, 63);
        tick();
        #1;
        check_output("dw_d_resp", bus.d_resp_valid, 1);
        check_output("dw_no_m_resp", bus.m_resp_valid, 0);
        tick();

        // Contention: four reads each, dealloc was served last so malloc leads.
        bus.m_req_valid = 1'b1;
        bus.m_req_we    = 1'b0;
        bus.m_req_addr  = 6'd1;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 6'd2;
        mg = 0; dg = 0; mr = 0; dr = 0; last_cyc = -1; exp_d = 1'b0;
        for (int cyc = 0; cyc < 40 && (mg + dg < 8 || mr + dr < 8); cyc++) begin
            #1;
            if (bus.m_resp_valid) begin
                mr++;
                check_output("rr_m_rdata", bus.m_resp_rdata, 8'h01);
            end
            if (bus.d_resp_valid) begin
                dr++;
                check_output("rr_d_rdata", bus.d_resp_rdata, 8'h02);
            end
            if (bus.m_req_ready && bus.d_req_ready) check_output("rr_one_hot", 1, 0);
            if (bus.m_req_ready || bus.d_req_ready) begin
                check_output("rr_side", bus.d_req_ready, exp_d);
                exp_d = !exp_d;
                if (last_cyc >= 0) check_output("rr_gap", cyc - last_cyc, 3);
                last_cyc = cyc;
                if (bus.m_req_ready) mg++;
                else                 dg++;
            end
            tick();
            if (mg == 4) bus.m_req_valid = 1'b0;
            if (dg == 4) bus.d_req_valid = 1'b0;
        end
        check_output("rr_m_grants", mg, 4);
        check_output("rr_d_grants", dg, 4);
        check_output("rr_m_resps", mr, 4);
        check_output("rr_d_resps", dr, 4);
`ifdef ACT_ARB_STATS_EN
        check_output("stat_conflict_nz", conflict_cnt != 0, 1);
`endif

        // act_bsy rises during ISSUE: the op is dropped.
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = 6'd5;
        #1;
        check_output("abort_ready", bus.m_req_ready, 1);
        tick();
        bus.m_req_valid = 1'b0;
        bus.act_bsy     = 1'b1;
        #1;
        check_output("abort_cs", bus.act_cs, 0);
        tick();
        #1;
        check_output("abort_no_resp", bus.m_resp_valid, 0);
        check_output("abort_arb_busy", arb_busy, 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.act_cs || bus.m_resp_valid || bus.m_req_ready) bad++;
        end
        check_output("abort_quiet", bad, 0);
        bus.act_bsy = 1'b0;
        tick();
        tick();
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = 6'd63;
        #1;
        check_output("resume_ready", bus.m_req_ready, 1);
        tick();
        bus.m_req_valid = 1'b0;
        #1;
        check_output("resume_cs", bus.act_cs, 1);
        tick();
        #1;
        check_output("resume_resp", bus.m_resp_valid, 1);
        check_output("resume_rdata", bus.m_resp_rdata, 8'h83);
`ifdef ACT_ARB_STATS_EN
        check_output("stat_drop", drop_cnt, 1);
`endif
        tick();

        // Asynchronous reset while a dealloc read sits in WAIT.
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 6'd2;
        #1;
        check_output("ar_ready", bus.d_req_ready, 1);
        tick();
        bus.d_req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_output("ar_d_resp", bus.d_resp_valid, 0);
        check_output("ar_arb_busy", arb_busy, 1);
        check_output("ar_cs", bus.act_cs, 0);
        check_output("ar_sel", bus.act_sel, 0);
        check_output("ar_d_addr", bus.act_d_addr, 0);
        check_output("ar_d_rdata", bus.d_resp_rdata, 0);
        check_output("ar_m_rdata", bus.m_resp_rdata, 0);
`ifdef ACT_ARB_STATS_EN
        check_output("ar_stat_m", m_grant_cnt, 0);
        check_output("ar_stat_drop", drop_cnt, 0);
`endif
        tick();
        check_output("ar_d_resp_held", bus.d_resp_valid, 0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
